// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the four byte requesters, the transmit arbiter and
// the UART transmitter. The master view belongs to the arbiter.
interface uart_tx_arbiter_if;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  active_ch;
    logic        busy;
    logic        timeout;

    modport master (
        input  req, data_in, tx_busy,
        output ack, tx_start, tx_data, active_ch, busy, timeout
    );

    modport slave (
        output req, data_in, tx_busy,
        input  ack, tx_start, tx_data, active_ch, busy, timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among four requesters.
// Each grant sends an optional channel-ID header byte followed by the payload.
module uart_tx_arbiter #(
    parameter bit          HEADER_EN     = 1'b1,
    parameter logic [7:0]  HDR_BASE      = 8'hA0,
    parameter int unsigned START_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    uart_tx_arbiter_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_WAIT_LO = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_C = 16'(START_TIMEOUT);

    state_t      state_r;
    logic        ph_r;
    logic [1:0]  last_r;
    logic [15:0] cnt_r;
    logic [7:0]  payload_r;
    logic [3:0]  ack_r;
    logic        tx_start_r;
    logic [7:0]  tx_data_r;
    logic [1:0]  active_ch_r;
    logic        busy_r;
    logic        timeout_r;

    logic [1:0]  grant_ch_s;
    logic [7:0]  grant_byte_s;
    logic [7:0]  hdr_byte_s;

    // Search last+1, last+2, last+3, last; the lowest offset that is requesting wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    assign grant_ch_s   = rr_pick(bus.req, last_r);
    assign grant_byte_s = bus.data_in[{grant_ch_s, 3'b000} +: 8];
    assign hdr_byte_s   = HDR_BASE | {6'b000000, grant_ch_s};

    assign bus.ack       = ack_r;
    assign bus.tx_start  = tx_start_r;
    assign bus.tx_data   = tx_data_r;
    assign bus.active_ch = active_ch_r;
    assign bus.busy      = busy_r;
    assign bus.timeout   = timeout_r;

    // Frame sequencer: grant, header/payload start pulses and start watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            ph_r        <= 1'b0;
            last_r      <= 2'd3;
            cnt_r       <= 16'd0;
            payload_r   <= 8'd0;
            ack_r       <= 4'b0000;
            tx_start_r  <= 1'b0;
            tx_data_r   <= 8'd0;
            active_ch_r <= 2'd0;
            busy_r      <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            ack_r      <= 4'b0000;
            tx_start_r <= 1'b0;
            timeout_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if ((bus.req != 4'b0000) && !bus.tx_busy) begin
                        payload_r   <= grant_byte_s;
                        ack_r       <= 4'b0001 << grant_ch_s;
                        active_ch_r <= grant_ch_s;
                        last_r      <= grant_ch_s;
                        tx_start_r  <= 1'b1;
                        if (HEADER_EN) begin
                            tx_data_r <= hdr_byte_s;
                            ph_r      <= 1'b0;
                        end else begin
                            tx_data_r <= grant_byte_s;
                            ph_r      <= 1'b1;
                        end
                        cnt_r   <= 16'd0;
                        state_r <= ST_WAIT_HI;
                        busy_r  <= 1'b1;
                    end
                end
                ST_WAIT_HI: begin
                    // A busy rise on the expiry edge still counts as a successful start.
                    if (bus.tx_busy) begin
                        state_r <= ST_WAIT_LO;
                    end else if (cnt_r == TIMEOUT_C) begin
                        timeout_r <= 1'b1;
                        state_r   <= ST_IDLE;
                        busy_r    <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_WAIT_LO: begin
                    if (!bus.tx_busy) begin
                        if (!ph_r) begin
                            tx_start_r <= 1'b1;
                            tx_data_r  <= payload_r;
                            ph_r       <= 1'b1;
                            cnt_r      <= 16'd0;
                            state_r    <= ST_WAIT_HI;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: randomized requests against a round-robin reference model,
// with behavioural transmitters that can stall, stretch or never start.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_arbiter_if ifa ();
    uart_tx_arbiter_if ifb ();

    uart_tx_arbiter #(.HEADER_EN(1'b1), .HDR_BASE(8'hA0), .START_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .bus(ifa)
    );

    uart_tx_arbiter #(.HEADER_EN(1'b0), .HDR_BASE(8'hA0), .START_TIMEOUT(16)) dut_nh (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    int checks = 0;
    int errors = 0;

    // reference model state: last granted channel
    int m_last = 3;

    // observation queues for dut
    logic [7:0] start_q[$];
    logic [7:0] rise_q[$];
    int         ack_q[$];
    int         multi_ack_a = 0;
    int         timeout_cnt_a = 0;
    int         xa_delay = 1;
    int         xa_len = 3;
    bit         xa_dead = 1'b0;

    // observation queues for dut_nh
    logic [7:0] start_q_b[$];
    int         ack_b_q[$];

    function automatic int rr_ref(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic string fmt_q(input logic [7:0] q[$]);
        string s;
        s = "";
        foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
        return s;
    endfunction

    // transmitter model + monitor for dut
    initial begin
        int xa_wait;
        int xa_left;
        xa_wait = 0;
        xa_left = 0;
        ifa.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (ifa.ack != 4'b0000) begin
                if ($countones(ifa.ack) > 1) multi_ack_a++;
                for (int i = 0; i < 4; i++) if (ifa.ack[i]) ack_q.push_back(i);
            end
            if (ifa.timeout) timeout_cnt_a++;
            if (ifa.tx_start) start_q.push_back(ifa.tx_data);
            if (ifa.tx_start && !xa_dead) begin
                if (xa_delay == 0) begin
                    ifa.tx_busy = 1'b1;
                    xa_left = xa_len;
                    rise_q.push_back(ifa.tx_data);
                end else begin
                    xa_wait = xa_delay;
                end
            end else if (xa_wait > 0) begin
                xa_wait--;
                if (xa_wait == 0) begin
                    ifa.tx_busy = 1'b1;
                    xa_left = xa_len;
                    rise_q.push_back(ifa.tx_data);
                end
            end else if (ifa.tx_busy) begin
                xa_left--;
                if (xa_left <= 0) ifa.tx_busy = 1'b0;
            end
        end
    end

    // transmitter model + monitor for dut_nh (busy 3 cycles, one cycle after start)
    initial begin
        int xb_wait;
        int xb_left;
        xb_wait = 0;
        xb_left = 0;
        ifb.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (ifb.ack[i]) ack_b_q.push_back(i);
            if (ifb.tx_start) begin
                start_q_b.push_back(ifb.tx_data);
                xb_wait = 1;
            end else if (xb_wait > 0) begin
                xb_wait--;
                if (xb_wait == 0) begin
                    ifb.tx_busy = 1'b1;
                    xb_left = 3;
                end
            end else if (ifb.tx_busy) begin
                xb_left--;
                if (xb_left <= 0) ifb.tx_busy = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle_a(input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            tick();
            if (!ifa.busy && !ifa.tx_busy) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_idle: busy=%0b tx_busy=%0b, required both 0 within 200 cycles", name, ifa.busy, ifa.tx_busy);
        end
    endtask

    // one full frame on dut, checked against the reference model
    task automatic serve_a(input string name, input logic [3:0] r, input logic [31:0] d);
        int         exp_ch;
        logic [7:0] exp_pl;
        logic [7:0] exp_hdr;
        logic [3:0] got_ack;
        bit         got;
        exp_ch = rr_ref(r, m_last);
        m_last = exp_ch;
        exp_pl = d[8*exp_ch +: 8];
        exp_hdr = 8'hA0 | 8'(exp_ch);
        start_q.delete();
        rise_q.delete();
        ack_q.delete();
        ifa.req = r;
        ifa.data_in = d;
        got = 1'b0;
        got_ack = 4'b0000;
        for (int n = 0; n < 64 && !got; n++) begin
            tick();
            if (ifa.ack != 4'b0000) begin
                got = 1'b1;
                got_ack = ifa.ack;
            end
        end
        ifa.req = 4'b0000;
        ifa.data_in = $urandom;
        checks++;
        if (!got || got_ack !== 4'(1 << exp_ch)) begin
            errors++;
            $display("FAIL %s_ack: got %b (seen=%0b), required %b", name, got_ack, got, 4'(1 << exp_ch));
        end
        checks++;
        if (ifa.tx_start !== 1'b1 || ifa.tx_data !== exp_hdr) begin
            errors++;
            $display("FAIL %s_start: tx_start=%0b tx_data=%02h, required 1 / %02h", name, ifa.tx_start, ifa.tx_data, exp_hdr);
        end
        wait_idle_a(name);
        checks++;
        if (ifa.active_ch !== 2'(exp_ch)) begin
            errors++;
            $display("FAIL %s_active_ch: got %0d, required %0d", name, ifa.active_ch, exp_ch);
        end
        checks++;
        if (start_q.size() != 2 || start_q[0] !== exp_hdr || start_q[1] !== exp_pl) begin
            errors++;
            $display("FAIL %s_bytes: started [%s], required [%02h %02h]", name, fmt_q(start_q), exp_hdr, exp_pl);
        end
        checks++;
        if (rise_q.size() != 2 || rise_q[0] !== exp_hdr || rise_q[1] !== exp_pl) begin
            errors++;
            $display("FAIL %s_hold: at busy rise [%s], required [%02h %02h]", name, fmt_q(rise_q), exp_hdr, exp_pl);
        end
        checks++;
        if (ack_q.size() != 1 || multi_ack_a != 0) begin
            errors++;
            $display("FAIL %s_ack_count: %0d acks, %0d multi-hot, required 1 and 0", name, ack_q.size(), multi_ack_a);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ifa.req = 4'b0000;
        ifa.data_in = 32'h0;
        ifb.req = 4'b0000;
        ifb.data_in = 32'h0;
        repeat (3) tick();
        checks++;
        if ({ifa.ack, ifa.tx_start, ifa.tx_data, ifa.active_ch, ifa.busy, ifa.timeout} !== 17'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0", {ifa.ack, ifa.tx_start, ifa.tx_data, ifa.active_ch, ifa.busy, ifa.timeout});
        end
        checks++;
        if ({ifb.ack, ifb.tx_start, ifb.tx_data, ifb.active_ch, ifb.busy, ifb.timeout} !== 17'b0) begin
            errors++;
            $display("FAIL reset_outputs_nh: got %h, required 0", {ifb.ack, ifb.tx_start, ifb.tx_data, ifb.active_ch, ifb.busy, ifb.timeout});
        end
        reset = 1'b0;
        m_last = 3;
        tick();
    endtask

    task automatic test_round_robin();
        int         cnt;
        int         ch;
        int         exp_ch[$];
        logic [7:0] exp_b[$];
        start_q.delete();
        ack_q.delete();
        ifa.req = 4'b1111;
        ifa.data_in = 32'h1312_1110;
        cnt = 0;
        for (int n = 0; n < 400 && cnt < 5; n++) begin
            tick();
            if (ifa.ack != 4'b0000) cnt++;
        end
        ifa.req = 4'b0000;
        wait_idle_a("rr");
        for (int i = 0; i < 5; i++) begin
            ch = rr_ref(4'b1111, m_last);
            m_last = ch;
            exp_ch.push_back(ch);
            exp_b.push_back(8'hA0 | 8'(ch));
            exp_b.push_back(8'h10 + 8'(ch));
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= ack_q.size() || ack_q[i] != exp_ch[i]) begin
                errors++;
                $display("FAIL rr_grant%0d: got %0d, required %0d", i, (i < ack_q.size()) ? ack_q[i] : -1, exp_ch[i]);
            end
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (i >= start_q.size() || start_q[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL rr_byte%0d: got [%s], required %02h at this slot", i, fmt_q(start_q), exp_b[i]);
            end
        end
    endtask

    task automatic test_single();
        xa_delay = 1;
        xa_len = 3;
        serve_a("single", 4'b0100, 32'h005A_0000);
    endtask

    task automatic test_skip();
        serve_a("skip_last1", 4'b0010, $urandom);
        serve_a("skip_ch0", 4'b0001, $urandom);
        serve_a("skip_ch3_first", 4'b1001, $urandom);
        serve_a("skip_ch0_next", 4'b1001, $urandom);
    endtask

    task automatic test_header_off();
        bit         got;
        bit         done;
        logic [3:0] got_ack;
        start_q_b.delete();
        ack_b_q.delete();
        ifb.req = 4'b0010;
        ifb.data_in = 32'h0000_C300;
        got = 1'b0;
        got_ack = 4'b0000;
        for (int n = 0; n < 64 && !got; n++) begin
            tick();
            if (ifb.ack != 4'b0000) begin
                got = 1'b1;
                got_ack = ifb.ack;
            end
        end
        ifb.req = 4'b0000;
        ifb.data_in = $urandom;
        checks++;
        if (!got || got_ack !== 4'b0010) begin
            errors++;
            $display("FAIL nohdr_ack: got %b, required 0010", got_ack);
        end
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            tick();
            if (!ifb.busy && !ifb.tx_busy) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL nohdr_idle: busy=%0b, required 0 within 100 cycles", ifb.busy);
        end
        checks++;
        if (start_q_b.size() != 1 || start_q_b[0] !== 8'hC3) begin
            errors++;
            $display("FAIL nohdr_bytes: started [%s], required [c3]", fmt_q(start_q_b));
        end
        checks++;
        if (ifb.active_ch !== 2'd1 || ack_b_q.size() != 1) begin
            errors++;
            $display("FAIL nohdr_active: active_ch=%0d acks=%0d, required 1 and 1", ifb.active_ch, ack_b_q.size());
        end
    endtask

    task automatic test_watchdog();
        int  n;
        int  t0;
        int  exp_ch;
        bit  got;
        xa_dead = 1'b1;
        start_q.delete();
        exp_ch = rr_ref(4'b0001, m_last);
        m_last = exp_ch;
        t0 = timeout_cnt_a;
        ifa.req = 4'b0001;
        ifa.data_in = $urandom;
        got = 1'b0;
        for (int k = 0; k < 64 && !got; k++) begin
            tick();
            if (ifa.ack != 4'b0000) got = 1'b1;
        end
        ifa.req = 4'b0000;
        n = 0;
        while (n < 40 && ifa.timeout !== 1'b1) begin
            tick();
            n++;
        end
        checks++;
        if (!got || n != 17) begin
            errors++;
            $display("FAIL wd_latency: timeout %0d cycles after tx_start (ack seen=%0b), required 17", n, got);
        end
        checks++;
        if (ifa.busy !== 1'b0) begin
            errors++;
            $display("FAIL wd_busy: busy=%0b with timeout, required 0", ifa.busy);
        end
        repeat (3) tick();
        checks++;
        if (timeout_cnt_a - t0 != 1 || start_q.size() != 1) begin
            errors++;
            $display("FAIL wd_once: %0d timeout pulses, %0d starts, required 1 and 1", timeout_cnt_a - t0, start_q.size());
        end
        xa_dead = 1'b0;
        serve_a("wd_recover", 4'($urandom_range(1, 15)), $urandom);
    endtask

    task automatic test_busy_edge();
        int t0;
        t0 = timeout_cnt_a;
        xa_delay = 16;
        xa_len = 2;
        serve_a("busy_at_expiry", 4'($urandom_range(1, 15)), $urandom);
        checks++;
        if (timeout_cnt_a != t0) begin
            errors++;
            $display("FAIL busy_at_expiry_timeout: %0d pulses, required 0", timeout_cnt_a - t0);
        end
        xa_delay = 1;
        xa_len = 3;
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            xa_delay = $urandom_range(0, 5);
            xa_len = $urandom_range(1, 5);
            serve_a($sformatf("rand%0d", it), 4'($urandom_range(1, 15)), $urandom);
            ifa.req = 4'b0000;
            tick();
            checks++;
            if (ifa.ack !== 4'b0000 || ifa.tx_start !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_quiet: ack=%b tx_start=%0b with no request, required 0", it, ifa.ack, ifa.tx_start);
            end
        end
        xa_delay = 1;
        xa_len = 3;
    endtask

    task automatic test_reset_midframe();
        bit got;
        bit hi;
        bit early_ack;
        xa_delay = 1;
        xa_len = 8;
        ifa.req = 4'b1111;
        ifa.data_in = $urandom;
        got = 1'b0;
        for (int n = 0; n < 64 && !got; n++) begin
            tick();
            if (ifa.ack != 4'b0000) got = 1'b1;
        end
        ifa.req = 4'b0000;
        hi = 1'b0;
        for (int n = 0; n < 32 && !hi; n++) begin
            tick();
            if (ifa.tx_busy) hi = 1'b1;
        end
        checks++;
        if (!got || !hi) begin
            errors++;
            $display("FAIL rst_mid_setup: ack seen=%0b busy seen=%0b, required 1 and 1", got, hi);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({ifa.ack, ifa.tx_start, ifa.tx_data, ifa.active_ch, ifa.busy, ifa.timeout} !== 17'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %h, required 0", {ifa.ack, ifa.tx_start, ifa.tx_data, ifa.active_ch, ifa.busy, ifa.timeout});
        end
        reset = 1'b0;
        m_last = 3;
        ifa.req = 4'b1111;
        early_ack = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            if (ifa.ack != 4'b0000 || ifa.tx_start) early_ack = 1'b1;
        end
        checks++;
        if (early_ack || ifa.tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_blocked: activity=%0b tx_busy=%0b, required no grant while transmitter busy", early_ack, ifa.tx_busy);
        end
        serve_a("rst_mid_first", 4'b1111, $urandom);
        xa_len = 3;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation bound expired");
        $fatal(1, "bench time limit");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_skip();
        test_header_off();
        test_watchdog();
        test_busy_edge();
        test_random();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin transmit scheduler that shares the single UART transmitter among four byte-producing requesters. It sits between client logic and the transmitter's `tx_start`/`tx_data`/`tx_busy` interface. For each granted request it sequences one frame: an optional channel-ID header byte, then the payload byte. A start-acknowledge watchdog detects a transmitter that never goes busy.

## Interface
Parameters:
- `HEADER_EN`, 1: 1 = send header byte before payload; 0 = payload only.
- `HDR_BASE`, 8'hA0: header byte value is `HDR_BASE | {6'b0, ch}`; `HDR_BASE[1:0]` must be 0.
- `START_TIMEOUT`, 16: max cycles to wait for `tx_busy` to rise after `tx_start`; 16-bit counter.

Ports:
- `clk` in 1: system clock, all logic rising-edge.
- `reset` in 1: synchronous, active-high.
- `req` in 4: per-channel request, level; bit i = channel i has a byte.
- `data_in` in 32: payload bytes, channel i at `[8*i+7:8*i]`.
- `ack` out 4: one-cycle pulse, bit i = channel i payload captured (pop).
- `tx_start` out 1: one-cycle start pulse to transmitter.
- `tx_data` out 8: byte to transmitter, stable from `tx_start` until `tx_busy` falls.
- `tx_busy` in 1: transmitter busy.
- `active_ch` out 2: channel of frame in progress (last granted when idle).
- `busy` out 1: high whenever state is not IDLE.
- `timeout` out 1: one-cycle pulse when the start watchdog expires.

## Operation
- State machine: IDLE, WAIT_HI, WAIT_LO. Phase bit `ph` (0 = header, 1 = payload). Register `last` (2 bits) holds the last granted channel.
- IDLE: if `req != 0` and `tx_busy == 0`, grant the first set bit searching `last+1, last+2, last+3, last` (mod 4).
  - Same edge: capture `data_in[ch]` into a payload register, set `ack[ch]`, set `active_ch = last = ch`, pulse `tx_start`.
  - `tx_data` = header with `ph = 0` if `HEADER_EN`, else payload with `ph = 1`.
  - Clear watchdog; go to WAIT_HI.
- IDLE with `tx_busy == 1`: no grant, no ack.
- WAIT_HI: counter increments each cycle.
  - `tx_busy == 1` → WAIT_LO.
  - Counter reaches `START_TIMEOUT` without busy → pulse `timeout`, drop frame (payload already acked, not retried), go to IDLE. `last` is kept.
- WAIT_LO: when `tx_busy == 0`:
  - `ph == 0`: pulse `tx_start`, `tx_data = payload`, `ph = 1`, clear counter, go to WAIT_HI.
  - `ph == 1`: go to IDLE.
- `req` is sampled only in IDLE. Requesters must treat `ack` as a pop: present the next byte, or drop `req`, on the cycle after `ack`. `req` held high after `ack` is a new request.
- `data_in` is ignored outside the grant cycle. The payload register protects against source changes.

## Timing
- Reset (synchronous, has priority over everything): state IDLE, `ph = 0`, `last = 3` (channel 0 wins first), counter 0. All outputs 0: `ack`, `tx_start`, `tx_data`, `active_ch`, `busy`, `timeout`.
- Reset mid-frame: aborts immediately. No further `tx_start`; the transmitter finishes its byte on its own.
- All outputs are registered.
- Grant latency: `req` seen high in IDLE at edge N → `ack` and `tx_start` high in cycle N+1, both for exactly one cycle.
- Payload start: `tx_busy` sampled low in WAIT_LO at edge M → payload `tx_start` in cycle M+1.
- Next grant: earliest one cycle after the payload's `tx_busy` fall is sampled (WAIT_LO → IDLE → grant).
- `timeout`: asserted in the cycle after the counter equals `START_TIMEOUT` while `tx_busy` has stayed 0.
- `tx_busy` rising on the same edge as the counter expiry counts as success: no timeout.
- At most one `ack` bit is high in any cycle. `tx_start` is never high while in WAIT_HI/WAIT_LO except on the entry edge.

## Test plan
- Single request: `req = 4'b0100`, `data_in[23:16] = 8'h5A`, `HEADER_EN = 1`, transmitter model busy 3 cycles after start → `ack = 4'b0100` once; bytes 8'hA2 then 8'h5A on `tx_data`, each with one `tx_start`; `active_ch = 2`.
- Round-robin fairness: `req = 4'b1111` held constantly, payloads 8'h10/8'h11/8'h12/8'h13 → grant order 0,1,2,3,0; header bytes A0,A1,A2,A3,A0.
- Skip of idle channels: `last = 1`, `req = 4'b0001` → channel 0 granted; then `req = 4'b1001` → channel 3 before channel 0.
- `HEADER_EN = 0`: `req = 4'b0010`, data 8'hC3 → exactly one `tx_start` with `tx_data = 8'hC3`; return to IDLE after busy falls.
- Watchdog: transmitter never raises busy, `START_TIMEOUT = 16` → `timeout` pulses once 17 cycles after `tx_start`; `busy` drops; next request served normally.
- Reset mid-frame: assert `reset` during WAIT_LO of the header byte → all outputs 0 next cycle, no payload `tx_start`; after release, `req = 4'b1111` grants channel 0 first.
